spy_chain_sequencer: RTL and testbench

Measurement controller for the inverting spy delay chains (e.g. a 100-stage chain of single-path elements). It launches a transition into the chain input and waits a programmable number of clock cycles. It then samples the chain output through a two-flop synchronizer and checks it against the expected value, counting mismatches over a programmed number of trials. Sits between the register/host interface and one chain instance; a mismatch means the chain delay exceeded the settle window.

---
 rtl/spy_seq_pkg.sv | 23 ++
 rtl/spy_sync2.sv | 24 ++
 rtl/spy_chain_sequencer.sv | 147 ++++++++++++++
 tb/tb_spy_chain_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spy_seq_pkg.sv
// Shared types and constants for the spy delay-chain measurement sequencer.
package spy_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } seqState_t;

   localparam int SPY_SETTLE_W_DEF = 8;
   localparam int SPY_TRIALS_W_DEF = 16;

   // Chain parity: 1 when the chain has an odd number of inverting stages.
   localparam bit SPY_P35_100_INVERTS = 1'b0;
   localparam bit SPY_ODD_INVERTS     = 1'b1;

   function automatic logic expectedSense(input logic drive, input logic inverts);
      return drive ^ inverts;
   endfunction

endpackage

// File: rtl/spy_sync2.sv
// Two-flop synchronizer bringing the asynchronous chain output into the clk domain.
module spy_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic syncMeta_r;
   logic syncOut_r;

   // Two-stage capture; both stages clear on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncMeta_r <= 1'b0;
         syncOut_r  <= 1'b0;
      end else begin
         syncMeta_r <= d;
         syncOut_r  <= syncMeta_r;
      end
   end

   assign q = syncOut_r;

endmodule

// File: rtl/spy_chain_sequencer.sv
// Spy delay-chain sequencer: launches edges into the chain, waits a programmed
// settle window, samples the synchronized chain output and counts mismatches.
module spy_chain_sequencer
   import spy_seq_pkg::*;
#(
   parameter int SETTLE_W      = SPY_SETTLE_W_DEF,
   parameter int TRIALS_W      = SPY_TRIALS_W_DEF,
   parameter bit CHAIN_INVERTS = SPY_P35_100_INVERTS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic [TRIALS_W-1:0] num_trials,
   output logic                path_drive,
   input  logic                path_sense,
   output logic                busy,
   output logic                done,
   output logic [TRIALS_W-1:0] trial_count,
   output logic [TRIALS_W-1:0] err_count,
   output logic                last_sample
);
   localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
   localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
   localparam logic [TRIALS_W-1:0] TRIALS_ZERO = {TRIALS_W{1'b0}};
   localparam logic [TRIALS_W-1:0] TRIALS_ONE  = {{(TRIALS_W-1){1'b0}}, 1'b1};

   seqState_t           state_r;
   seqState_t           stateNext_s;
   logic [SETTLE_W-1:0] settleLat_r;
   logic [SETTLE_W-1:0] settleCnt_r;
   logic [SETTLE_W-1:0] settleEff_s;
   logic [TRIALS_W-1:0] trialsLat_r;
   logic [TRIALS_W-1:0] trialCount_r;
   logic [TRIALS_W-1:0] trialInc_s;
   logic [TRIALS_W-1:0] errCount_r;
   logic                pathDrive_r;
   logic                busy_r;
   logic                done_r;
   logic                lastSample_r;
   logic                syncSense_s;
   logic                mismatch_s;

   spy_sync2 u_senseSync (
      .clk (clk),
      .rst (rst),
      .d   (path_sense),
      .q   (syncSense_s)
   );

   // A zero settle request still needs one settle cycle.
   assign settleEff_s = (settleLat_r == SETTLE_ZERO) ? SETTLE_ONE : settleLat_r;
   assign trialInc_s  = trialCount_r + TRIALS_ONE;
   assign mismatch_s  = (syncSense_s != expectedSense(pathDrive_r, CHAIN_INVERTS));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // Next-state decode.
   always_comb begin
      stateNext_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               stateNext_s = (num_trials == TRIALS_ZERO) ? DONE : LAUNCH;
            end else begin
               stateNext_s = IDLE;
            end
         end
         LAUNCH: stateNext_s = SETTLE;
         SETTLE: begin
            if (settleCnt_r == SETTLE_ONE) begin
               stateNext_s = SAMPLE;
            end else begin
               stateNext_s = SETTLE;
            end
         end
         SAMPLE: begin
            if (trialInc_s == trialsLat_r) begin
               stateNext_s = DONE;
            end else begin
               stateNext_s = LAUNCH;
            end
         end
         DONE:    stateNext_s = IDLE;
         default: stateNext_s = IDLE;
      endcase
   end

   // Datapath: latches, settle counter, chain drive, result counters and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settleLat_r  <= SETTLE_ZERO;
         settleCnt_r  <= SETTLE_ZERO;
         trialsLat_r  <= TRIALS_ZERO;
         trialCount_r <= TRIALS_ZERO;
         errCount_r   <= TRIALS_ZERO;
         pathDrive_r  <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         lastSample_r <= 1'b0;
      end else begin
         busy_r <= (stateNext_s != IDLE);
         done_r <= (stateNext_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  settleLat_r  <= settle_cycles;
                  trialsLat_r  <= num_trials;
                  trialCount_r <= TRIALS_ZERO;
                  errCount_r   <= TRIALS_ZERO;
               end
            end
            LAUNCH: begin
               pathDrive_r <= ~pathDrive_r;
               settleCnt_r <= settleEff_s;
            end
            SETTLE: settleCnt_r <= settleCnt_r - SETTLE_ONE;
            SAMPLE: begin
               lastSample_r <= syncSense_s;
               trialCount_r <= trialInc_s;
               // Saturate rather than wrap so a long failing run never reads as clean.
               if (mismatch_s && !(&errCount_r)) begin
                  errCount_r <= errCount_r + TRIALS_ONE;
               end
            end
            default: begin
               settleCnt_r <= settleCnt_r;
            end
         endcase
      end
   end

   assign path_drive  = pathDrive_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign trial_count = trialCount_r;
   assign err_count   = errCount_r;
   assign last_sample = lastSample_r;

endmodule

// File: tb/tb_spy_chain_sequencer.sv
// Self-checking bench for spy_chain_sequencer: default, inverting-parity and
// narrow-counter instances checked against a scoreboard of modelled run results.
module tb_spy_chain_sequencer;
   import spy_seq_pkg::*;

   typedef struct {
      int   cycles;
      int   trials;
      int   errs;
      logic drive;
      logic last;
      bit   checkLast;
   } exp_t;

   typedef struct packed {
      logic        done;
      logic        busy;
      logic        drive;
      logic        last;
      logic [15:0] trial;
      logic [15:0] err;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  settleCycles = 8'd0;
   logic [15:0] numTrials = 16'd0;
   logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic        useDelay = 1'b0;
   logic [2:0]  dly_r = 3'd0;
   logic        drive0, drive1, drive2, sense0, sense1, sense2;
   logic        busy0, busy1, busy2, done0, done1, done2, last0, last1, last2;
   logic [15:0] trial0, err0, trial1, err1;
   logic [3:0]  trial2, err2;
   logic        modelDrive [3];
   exp_t        sbQ [$];
   int          checks = 0;
   int          passes = 0;

   always #5 clk = ~clk;

   // Three-cycle chain delay model for dut0.
   always @(posedge clk) dly_r <= {dly_r[1:0], drive0};
   assign sense0 = useDelay ? dly_r[2] : drive0;
   assign sense1 = ~drive1;
   assign sense2 = drive2;

   spy_chain_sequencer dut0 (
      .clk(clk), .rst(rst), .start(start0), .settle_cycles(settleCycles),
      .num_trials(numTrials), .path_drive(drive0), .path_sense(sense0), .busy(busy0),
      .done(done0), .trial_count(trial0), .err_count(err0), .last_sample(last0));

   spy_chain_sequencer #(.CHAIN_INVERTS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .settle_cycles(settleCycles),
      .num_trials(numTrials), .path_drive(drive1), .path_sense(sense1), .busy(busy1),
      .done(done1), .trial_count(trial1), .err_count(err1), .last_sample(last1));

   spy_chain_sequencer #(.TRIALS_W(4)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .settle_cycles(settleCycles),
      .num_trials(numTrials[3:0]), .path_drive(drive2), .path_sense(sense2), .busy(busy2),
      .done(done2), .trial_count(trial2), .err_count(err2), .last_sample(last2));

   function automatic obs_t sampleDut(input int w);
      obs_t o;
      case (w)
         1:       o = '{done1, busy1, drive1, last1, trial1, err1};
         2:       o = '{done2, busy2, drive2, last2, {12'd0, trial2}, {12'd0, err2}};
         default: o = '{done0, busy0, drive0, last0, trial0, err0};
      endcase
      return o;
   endfunction

   task automatic setStart(input int w, input logic v);
      case (w)
         1:       start1 = v;
         2:       start2 = v;
         default: start0 = v;
      endcase
   endtask

   // Reference model of one run: timing, counts, final drive and last sample.
   function automatic exp_t modelRun(input int w, input int s, input int n, input int delay, input int cap);
      exp_t e;
      int   seff;
      seff = (s == 0) ? 1 : s;
      e.cycles = 1 + n * (seff + 2);
      e.trials = n;
      e.errs = (seff < delay + 2) ? n : 0;
      if (e.errs > cap) e.errs = cap;
      e.drive = modelDrive[w] ^ n[0];
      e.last = e.drive ^ (w == 1) ^ (e.errs > 0);
      e.checkLast = (n > 0);
      modelDrive[w] = e.drive;
      return e;
   endfunction

   task automatic runDut(input int w, input int s, input int n, input bit hold,
                         output obs_t o, output int cyc, output bit busyOk, output bit pulseOk);
      bit seen;
      seen = 0; busyOk = 1; pulseOk = 0; cyc = 0;
      @(negedge clk);
      settleCycles = s[7:0];
      numTrials = n[15:0];
      setStart(w, 1'b1);
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         cyc++;
         if (!hold) setStart(w, 1'b0);
         o = sampleDut(w);
         if (o.done) seen = 1;
         else if (!o.busy) busyOk = 0;
      end
      setStart(w, 1'b0);
      if (!seen) begin
         cyc = -1;
      end else begin
         @(negedge clk);
         pulseOk = !sampleDut(w).done;
      end
   endtask

   task automatic test_reset();
      obs_t o;
      for (int w = 0; w < 3; w++) begin
         o = sampleDut(w);
         checks++;
         if (o !== 36'd0) $display("FAIL reset_outputs dut%0d: got %h expected 0", w, o);
         else passes++;
      end
   endtask

   task automatic test_ideal();
      exp_t e; obs_t o; int cyc; bit bOk, pOk;
      sbQ.push_back(modelRun(0, 4, 10, 0, 65535));
      runDut(0, 4, 10, 0, o, cyc, bOk, pOk);
      e = sbQ.pop_front();
      checks++; if (cyc !== e.cycles) $display("FAIL ideal_cycles: got %0d expected %0d", cyc, e.cycles); else passes++;
      checks++; if (int'(o.trial) !== e.trials) $display("FAIL ideal_trials: got %0d expected %0d", o.trial, e.trials); else passes++;
      checks++; if (int'(o.err) !== e.errs) $display("FAIL ideal_errs: got %0d expected %0d", o.err, e.errs); else passes++;
      checks++; if (o.drive !== e.drive) $display("FAIL ideal_drive: got %b expected %b", o.drive, e.drive); else passes++;
      checks++; if (o.last !== e.last) $display("FAIL ideal_last: got %b expected %b", o.last, e.last); else passes++;
      checks++; if (bOk !== 1'b1) $display("FAIL ideal_busy: got %b expected 1", bOk); else passes++;
      checks++; if (pOk !== 1'b1) $display("FAIL ideal_done_pulse: got %b expected 1", pOk); else passes++;
   endtask

   task automatic test_short_settle();
      exp_t e; obs_t o; int cyc; bit bOk, pOk;
      sbQ.push_back(modelRun(0, 1, 5, 0, 65535));
      runDut(0, 1, 5, 0, o, cyc, bOk, pOk);
      e = sbQ.pop_front();
      checks++; if (cyc !== e.cycles) $display("FAIL s1_cycles: got %0d expected %0d", cyc, e.cycles); else passes++;
      checks++; if (int'(o.trial) !== e.trials) $display("FAIL s1_trials: got %0d expected %0d", o.trial, e.trials); else passes++;
      checks++; if (int'(o.err) !== e.errs) $display("FAIL s1_errs: got %0d expected %0d", o.err, e.errs); else passes++;
      checks++; if (o.last !== e.last) $display("FAIL s1_last: got %b expected %b", o.last, e.last); else passes++;
      checks++; if (o.drive !== e.drive) $display("FAIL s1_drive: got %b expected %b", o.drive, e.drive); else passes++;
   endtask

   task automatic test_delay_chain();
      exp_t e; obs_t o; int cyc; bit bOk, pOk;
      int sTab [2] = '{3, 6};
      useDelay = 1'b1;
      foreach (sTab[k]) begin
         sbQ.push_back(modelRun(0, sTab[k], 8, 3, 65535));
         runDut(0, sTab[k], 8, 0, o, cyc, bOk, pOk);
         e = sbQ.pop_front();
         checks++; if (cyc !== e.cycles) $display("FAIL delay_cycles S=%0d: got %0d expected %0d", sTab[k], cyc, e.cycles); else passes++;
         checks++; if (int'(o.err) !== e.errs) $display("FAIL delay_errs S=%0d: got %0d expected %0d", sTab[k], o.err, e.errs); else passes++;
         checks++; if (int'(o.trial) !== e.trials) $display("FAIL delay_trials S=%0d: got %0d expected %0d", sTab[k], o.trial, e.trials); else passes++;
         checks++; if (o.last !== e.last) $display("FAIL delay_last S=%0d: got %b expected %b", sTab[k], o.last, e.last); else passes++;
      end
      useDelay = 1'b0;
   endtask

   task automatic test_zero_trials();
      exp_t e; obs_t o; int cyc; bit bOk, pOk;
      sbQ.push_back(modelRun(0, 5, 0, 0, 65535));
      runDut(0, 5, 0, 0, o, cyc, bOk, pOk);
      e = sbQ.pop_front();
      checks++; if (cyc !== e.cycles) $display("FAIL zero_cycles: got %0d expected %0d", cyc, e.cycles); else passes++;
      checks++; if ({o.trial, o.err} !== 32'd0) $display("FAIL zero_counts: got %0d/%0d expected 0/0", o.trial, o.err); else passes++;
      checks++; if (o.drive !== e.drive) $display("FAIL zero_drive: got %b expected %b", o.drive, e.drive); else passes++;
      checks++; if (pOk !== 1'b1) $display("FAIL zero_done_pulse: got %b expected 1", pOk); else passes++;
   endtask

   task automatic test_back_to_back();
      exp_t e; obs_t o; int cyc; bit bOk, pOk;
      sbQ.push_back(modelRun(0, 2, 4, 0, 65535));
      runDut(0, 2, 4, 1, o, cyc, bOk, pOk);
      e = sbQ.pop_front();
      checks++; if (cyc !== e.cycles) $display("FAIL held_start_cycles: got %0d expected %0d", cyc, e.cycles); else passes++;
      checks++; if (int'(o.trial) !== e.trials) $display("FAIL held_start_trials: got %0d expected %0d", o.trial, e.trials); else passes++;
      checks++; if (int'(o.err) !== e.errs) $display("FAIL held_start_errs: got %0d expected %0d", o.err, e.errs); else passes++;
      checks++; if (o.drive !== e.drive) $display("FAIL held_start_drive: got %b expected %b", o.drive, e.drive); else passes++;
   endtask

   task automatic test_reset_mid_run();
      exp_t e; obs_t o; int cyc; bit bOk, pOk, seen;
      seen = 0;
      @(negedge clk);
      settleCycles = 8'd4; numTrials = 16'd10; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (trial0 == 16'd2) seen = 1;
         else @(negedge clk);
      end
      checks++; if (seen !== 1'b1) $display("FAIL midrun_reach_trial3: got %b expected 1", seen); else passes++;
      // Two cycles into the third trial's settle window.
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      o = sampleDut(0);
      checks++; if (o !== 36'd0) $display("FAIL midrun_reset_outputs: got %h expected 0", o); else passes++;
      checks++; if (dut0.state_r !== IDLE) $display("FAIL midrun_reset_state: got %0d expected %0d", dut0.state_r, IDLE); else passes++;
      @(negedge clk);
      rst = 1'b0;
      for (int w = 0; w < 3; w++) modelDrive[w] = 1'b0;
      sbQ.push_back(modelRun(0, 2, 3, 0, 65535));
      runDut(0, 2, 3, 0, o, cyc, bOk, pOk);
      e = sbQ.pop_front();
      checks++; if (cyc !== e.cycles) $display("FAIL post_reset_cycles: got %0d expected %0d", cyc, e.cycles); else passes++;
      checks++; if (int'(o.trial) !== e.trials) $display("FAIL post_reset_trials: got %0d expected %0d", o.trial, e.trials); else passes++;
      checks++; if (int'(o.err) !== e.errs) $display("FAIL post_reset_errs: got %0d expected %0d", o.err, e.errs); else passes++;
      checks++; if (o.drive !== e.drive) $display("FAIL post_reset_drive: got %b expected %b", o.drive, e.drive); else passes++;
   endtask

   task automatic test_parity();
      exp_t e; obs_t o; int cyc; bit bOk, pOk;
      sbQ.push_back(modelRun(1, 3, 4, 0, 65535));
      runDut(1, 3, 4, 0, o, cyc, bOk, pOk);
      e = sbQ.pop_front();
      checks++; if (cyc !== e.cycles) $display("FAIL parity_cycles: got %0d expected %0d", cyc, e.cycles); else passes++;
      checks++; if (int'(o.err) !== e.errs) $display("FAIL parity_errs: got %0d expected %0d", o.err, e.errs); else passes++;
      checks++; if (int'(o.trial) !== e.trials) $display("FAIL parity_trials: got %0d expected %0d", o.trial, e.trials); else passes++;
      checks++; if (o.last !== e.last) $display("FAIL parity_last: got %b expected %b", o.last, e.last); else passes++;
   endtask

   task automatic test_saturation();
      exp_t e; obs_t o; int cyc; bit bOk, pOk;
      sbQ.push_back(modelRun(2, 1, 15, 0, 15));
      runDut(2, 1, 15, 0, o, cyc, bOk, pOk);
      e = sbQ.pop_front();
      checks++; if (cyc !== e.cycles) $display("FAIL sat_cycles: got %0d expected %0d", cyc, e.cycles); else passes++;
      checks++; if (int'(o.err) !== e.errs) $display("FAIL sat_errs: got %0d expected %0d", o.err, e.errs); else passes++;
      checks++; if (int'(o.trial) !== e.trials) $display("FAIL sat_trials: got %0d expected %0d", o.trial, e.trials); else passes++;
      checks++; if (o.drive !== e.drive) $display("FAIL sat_drive: got %b expected %b", o.drive, e.drive); else passes++;
   endtask

   initial begin
      for (int w = 0; w < 3; w++) modelDrive[w] = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      test_ideal();
      test_short_settle();
      test_delay_chain();
      test_zero_trials();
      test_back_to_back();
      test_reset_mid_run();
      test_parity();
      test_saturation();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
